// File: rtl/definitions_pkg.sv
`default_nettype none
// ============================================================================
// Module   : definitions_pkg
// Brief    : Shared types and constants for the DMA controller slice.
// Revision : 1.0 - initial release
// ============================================================================
package definitions_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } dma_state_e;

  // Each beat moves one 32-bit word
  localparam int unsigned WORD_BYTES = 4;

  // A command address is usable only when it is word aligned
  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_ctrl_if
// Brief    : Memory-side beat bus between the DMA controller and the
//            imem/dmem port plus the external-buffer ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface dma_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              ext_rdy;
  logic              dma_dm_to_id;
  logic              dma_id_to_dm;
  logic              dma_imem_select;
  logic [ADDR_W-1:0] dma_addr;

  // DMA controller side
  modport master (
    input  ext_rdy,
    output dma_dm_to_id,
    output dma_id_to_dm,
    output dma_imem_select,
    output dma_addr
  );

  // Memory / buffer side
  modport slave (
    output ext_rdy,
    input  dma_dm_to_id,
    input  dma_id_to_dm,
    input  dma_imem_select,
    input  dma_addr
  );
endinterface
`default_nettype wire

// File: rtl/dma_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : dma_addr_gen
// Brief    : Beat address and remaining-word counter. Load takes the
//            command base/length; each step advances one word.
// Revision : 1.0 - initial release
// ============================================================================
module dma_addr_gen
  import definitions_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              load,
  input  wire logic              step,
  input  wire logic [ADDR_W-1:0] load_addr,
  input  wire logic [LEN_W-1:0]  load_len,
  output logic      [ADDR_W-1:0] addr,
  output logic      [LEN_W-1:0]  remaining,
  output logic                   last
);

  // Address and count registers; address wraps naturally at 2^ADDR_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      addr      <= addr + ADDR_W'(WORD_BYTES);
      remaining <= remaining - LEN_W'(1);
    end
  end

  // The beat being issued now is the final one of the command
  always_comb begin
    last = (remaining == LEN_W'(1));
  end

endmodule
`default_nettype wire

// File: rtl/dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dma_ctrl
// Brief    : Single-channel word DMA between an external buffer and
//            imem/dmem. One beat per ready cycle, abort, alignment check.
// Revision : 1.0 - initial release
// ============================================================================
module dma_ctrl
  import definitions_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start,
  input  wire logic              dir,
  input  wire logic              imem_sel,
  input  wire logic [ADDR_W-1:0] base_addr,
  input  wire logic [LEN_W-1:0]  len,
  input  wire logic              abort,
  dma_ctrl_if.master             mem,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  dma_state_e        state;
  dma_state_e        state_nxt;
  logic              dir_q;
  logic              sel_q;
  logic              err_q;
  logic              load;
  logic              beat;
  logic              err_set;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic              last;

  dma_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (beat),
    .load_addr (base_addr),
    .load_len  (len),
    .addr      (addr),
    .remaining (remaining),
    .last      (last)
  );

  // State register plus the latched command attributes and err pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dir_q <= 1'b0;
      sel_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_set;
      if (load) begin
        dir_q <= dir;
        sel_q <= imem_sel;
      end
    end
  end

  // Next-state and beat decode; a zero-length command spends one
  // beatless cycle in XFER before reporting DONE
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    beat      = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (word_aligned(base_addr[1:0])) begin
            load      = 1'b1;
            state_nxt = XFER;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      XFER: begin
        if (abort) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end else if (remaining == '0) begin
          state_nxt = DONE;
        end else if (mem.ext_rdy) begin
          beat = 1'b1;
          if (last) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Beat strobes are qualified so the bus is quiet between beats
  always_comb begin
    mem.dma_dm_to_id    = beat & ~dir_q;
    mem.dma_id_to_dm    = beat &  dir_q;
    mem.dma_imem_select = beat &  sel_q;
    mem.dma_addr        = addr;
    busy                = (state != IDLE);
    done                = (state == DONE);
    err                 = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_ctrl
// Brief    : Self-checking bench for dma_ctrl: directed scenarios with
//            literal expectations plus randomized traffic against a
//            queue-based transfer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        dir;
  logic        imem_sel;
  logic [31:0] base_addr;
  logic [15:0] len;
  logic        abort;
  logic        busy;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  dma_ctrl_if #(.ADDR_W(32)) mem_if ();

  dma_ctrl #(
    .ADDR_W (32),
    .LEN_W  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dir       (dir),
    .imem_sel  (imem_sel),
    .base_addr (base_addr),
    .len       (len),
    .abort     (abort),
    .mem       (mem_if),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 transferring, 2 completion cycle
  int          m_mode = 0;
  logic        m_dir  = 1'b0;
  logic        m_sel  = 1'b0;
  logic        m_err  = 1'b0;
  logic [31:0] m_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_err  = 1'b0;
      m_q.delete();
    end else begin
      logic new_err;
      new_err = 1'b0;
      case (m_mode)
        0: if (start) begin
          if (base_addr[1:0] != 2'b00) begin
            new_err = 1'b1;
          end else begin
            m_mode = 1;
            m_dir  = dir;
            m_sel  = imem_sel;
            for (int i = 0; i < int'(len); i++) m_q.push_back(base_addr + 32'(4 * i));
          end
        end
        1: begin
          if (abort) begin
            m_mode  = 0;
            new_err = 1'b1;
            m_q.delete();
          end else if (m_q.size() == 0) begin
            m_mode = 2;
          end else if (mem_if.ext_rdy) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_mode = 2;
          end
        end
        default: m_mode = 0;
      endcase
      m_err = new_err;
    end
  end

  // Compare DUT outputs with the model in the middle of every cycle
  always @(negedge clk) begin
    logic exp_beat;
    if (!rst_n) begin
      chk("rst_outputs", {busy, done, err, mem_if.dma_dm_to_id, mem_if.dma_id_to_dm,
                          mem_if.dma_imem_select}, 32'h0);
      chk("rst_addr", mem_if.dma_addr, 32'h0);
    end else begin
      exp_beat = (m_mode == 1) && mem_if.ext_rdy && !abort && (m_q.size() > 0);
      chk("m_wr",    mem_if.dma_dm_to_id,    exp_beat && !m_dir);
      chk("m_rd",    mem_if.dma_id_to_dm,    exp_beat &&  m_dir);
      chk("m_isel",  mem_if.dma_imem_select, exp_beat &&  m_sel);
      chk("m_busy",  busy, m_mode != 0);
      chk("m_done",  done, m_mode == 2);
      chk("m_err",   err,  m_err);
      if (exp_beat) chk("m_addr", mem_if.dma_addr, m_q[0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic s, input logic d, input logic sel,
                     input logic [31:0] b, input logic [15:0] l);
    start     = s;
    dir       = d;
    imem_sel  = sel;
    base_addr = b;
    len       = l;
  endtask

  task automatic beat_chk(input string name, input logic wr, input logic rd,
                          input logic sel, input logic [31:0] a);
    #1;
    chk({name, "_wr"},  mem_if.dma_dm_to_id, wr);
    chk({name, "_rd"},  mem_if.dma_id_to_dm, rd);
    chk({name, "_sel"}, mem_if.dma_imem_select, sel);
    if (wr || rd) chk({name, "_addr"}, mem_if.dma_addr, a);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd(0, 0, 0, 0, 0);
    abort = 1'b0;
    mem_if.ext_rdy = 1'b0;
    tick();
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_addr", mem_if.dma_addr, 0);
    rst_n = 1'b1;
    tick();

    // Write of 4 words at 0x100 with continuous ready
    cmd(1, 0, 0, 32'h100, 16'd4);
    mem_if.ext_rdy = 1'b1;
    tick();
    cmd(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      beat_chk("wr4", 1, 0, 0, 32'h100 + 32'(4 * i));
      chk("wr4_busy", busy, 1);
      tick();
    end
    #1 chk("wr4_done", done, 1);
    chk("wr4_nobeat", mem_if.dma_dm_to_id, 0);
    tick();
    #1 chk("wr4_idle", {busy, done}, 0);

    // Read of 3 words from imem with gapped ready
    tick();
    cmd(1, 1, 1, 32'h0, 16'd3);
    tick();
    cmd(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      mem_if.ext_rdy = (i % 2 == 0);
      beat_chk("rd3", 0, (i % 2 == 0), (i % 2 == 0), 32'(2 * i));
      tick();
    end
    #1 chk("rd3_done", done, 1);
    mem_if.ext_rdy = 1'b1;
    tick();

    // Zero length: busy two cycles, done on the second
    cmd(1, 0, 0, 32'h40, 16'd0);
    tick();
    cmd(0, 0, 0, 0, 0);
    beat_chk("len0_c1", 0, 0, 0, 0);
    chk("len0_c1_busy", {busy, done}, 2'b10);
    tick();
    #1 chk("len0_c2", {busy, done}, 2'b11);
    tick();
    #1 chk("len0_c3", {busy, done}, 2'b00);

    // Misaligned base: err pulse, never busy
    cmd(1, 0, 0, 32'h102, 16'd5);
    tick();
    cmd(0, 0, 0, 0, 0);
    #1 chk("misal_c1", {busy, err, mem_if.dma_dm_to_id}, 3'b010);
    tick();
    #1 chk("misal_c2", {busy, err}, 2'b00);

    // Address wrap
    cmd(1, 0, 1, 32'hFFFF_FFF8, 16'd3);
    tick();
    cmd(0, 0, 0, 0, 0);
    beat_chk("wrap0", 1, 0, 1, 32'hFFFF_FFF8);
    tick();
    beat_chk("wrap1", 1, 0, 1, 32'hFFFF_FFFC);
    tick();
    beat_chk("wrap2", 1, 0, 1, 32'h0000_0000);
    tick();
    #1 chk("wrap_done", done, 1);
    tick();

    // Abort on the second beat, with a competing start while busy
    cmd(1, 0, 0, 32'h200, 16'd8);
    tick();
    cmd(0, 0, 0, 0, 0);
    beat_chk("abt_b1", 1, 0, 0, 32'h200);
    tick();
    abort = 1'b1;
    cmd(1, 1, 1, 32'h300, 16'd2);
    beat_chk("abt_b2", 0, 0, 0, 0);
    tick();
    abort = 1'b0;
    cmd(0, 0, 0, 0, 0);
    #1 chk("abt_err", {busy, done, err}, 3'b001);
    tick();
    #1 chk("abt_after", {busy, done, err}, 3'b000);

    // Reset dropped mid-transfer
    cmd(1, 1, 0, 32'h40, 16'd6);
    tick();
    cmd(0, 0, 0, 0, 0);
    tick();
    #1 rst_n = 1'b0;
    #1 chk("async_rst", {busy, done, err, mem_if.dma_dm_to_id, mem_if.dma_id_to_dm,
                         mem_if.dma_imem_select}, 32'h0);
    chk("async_rst_addr", mem_if.dma_addr, 32'h0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    #1 chk("post_rst_quiet", {busy, done, err}, 3'b000);
    cmd(1, 0, 0, 32'h80, 16'd1);
    tick();
    cmd(0, 0, 0, 0, 0);
    beat_chk("post_rst_beat", 1, 0, 0, 32'h80);
    tick();
    #1 chk("post_rst_done", {busy, done}, 2'b11);
    tick();

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 600; c++) begin
      int unsigned r;
      logic [31:0] b;
      r = $urandom_range(0, 9);
      b = $urandom() & 32'hFFFF_FFFC;
      if (r == 0)      b = b | 32'($urandom_range(1, 3));
      else if (r == 1) b = 32'hFFFF_FFF0 | ($urandom() & 32'hC);
      cmd(($urandom_range(0, 5) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
          b, 16'($urandom_range(0, 6)));
      abort          = ($urandom_range(0, 24) == 0);
      mem_if.ext_rdy = ($urandom_range(0, 9) < 7);
      tick();
    end
    cmd(0, 0, 0, 0, 0);
    abort = 1'b0;
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
